ddr_tx_serializer: RTL
======================

DDR_TX_SERIALIZER -- requirements
Module: ddr_tx_serializer

Interface
REQ-001 Parameter DW, default 8: word width in bits; even, >= 2.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in words; power of two, >= 2.
REQ-003 clk  input  1  single clock; posedge and negedge both used.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DW  parallel word to transmit.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  FIFO can accept a word.
REQ-008 en  input  1  permits start of a new word.
REQ-009 dq  output  1  DDR serial data: even bit in clk-high phase, odd bit in clk-low phase.
REQ-010 dq_frame  output  1  SDR strobe, high for every cycle carrying a valid bit pair.
REQ-011 busy  output  1  shifter holds a word in transmission.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  words held in the FIFO.

Function
REQ-013 "Cycle N" is the clk period following posedge N.
REQ-014 Push occurs on a posedge with in_valid && in_ready; in_ready = !full; no bypass of a full FIFO.
REQ-015 Simultaneous push and pop leaves fifo_count unchanged; the popped word is the oldest.
REQ-016 States: IDLE, SEND.
REQ-017 IDLE -> SEND: on a posedge with en=1 and FIFO non-empty; pop into shifter; beat counter = 0.
REQ-018 SEND: each cycle transmits bits [2k] and [2k+1] of the word, LSB first; k = beat counter, 0..DW/2-1.
REQ-019 Last beat with en=1 and FIFO non-empty: pop the next word, stay in SEND, no gap cycle.
REQ-020 Last beat with en=0 or FIFO empty: go to IDLE.
REQ-021 en=0 during a word: the current word completes; only new loads are blocked.
REQ-022 Latency: word pushed at posedge 0 into an empty FIFO while IDLE with en=1 is popped at posedge 1; bits 0/1 appear in cycle 2; dq_frame is high for cycles 2 .. 2+DW/2-1.
REQ-023 DDR output is an XOR pair:
  - posedge flop p <= even_bit ^ n
  - negedge flop n <= odd_bit ^ p
  - dq = p ^ n
REQ-024 odd_bit is held in a posedge register so it is stable from the posedge to the following negedge.
REQ-025 When not transmitting, even_bit = odd_bit = 0, so dq = 0.
REQ-026 dq_frame and busy are posedge registers; both are high exactly in the cycles carrying data.

Reset
REQ-027 rst_n low asynchronously clears every flop, including the negedge flop n.
REQ-028 Reset values: dq=0, dq_frame=0, busy=0, fifo_count=0, in_ready=1, state=IDLE.
REQ-029 Reset mid-word or with a non-empty FIFO discards all data; no partial word resumes.
REQ-030 Release of rst_n starts operation from IDLE at the next posedge.

Structure
REQ-031 Package ddr_tx_pkg holds:
  - state enum {IDLE, SEND}
  - DW and DEPTH defaults
  - beat-counter width function
REQ-032 Sub-module ddr_tx_fifo: synchronous FIFO with push, pop, full, empty and count.
REQ-033 Shifter, beat counter, FSM and the XOR DDR pair live in the top module.
REQ-034 The negedge flop is the only negedge element.

Verification
REQ-035 Single 0xA5, en=1, FIFO empty -> dq by half-cycles 1,0,1,0,0,1,0,1 over cycles 2-5; dq_frame high for exactly cycles 2-5.
REQ-036 Back-to-back 0x01 then 0x80 -> 8 contiguous dq_frame cycles; dq = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; no gap cycle.
REQ-037 en=0, push 5 words on consecutive cycles -> in_ready low after the 4th push, fifo_count=4, 5th word not accepted; en=1 -> 4 words sent in order.
REQ-038 en drops in the 2nd beat of 0xFF with a 2nd word queued -> 0xFF completes (8 ones); then IDLE, dq=0, fifo_count=1.
REQ-039 rst_n low asynchronously mid-word (negedge phase) -> dq, dq_frame and busy go to 0 immediately; fifo_count=0 after release; next pushed word transmits correctly.
REQ-040 Every DDR half-cycle is checked against a reference bit stream on both clk edges, with no X on dq after reset.

Source files
------------

// File: rtl/ddr_tx_pkg.sv
// Shared types and defaults for the DDR transmit serializer.
package ddr_tx_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  // Beat counter indexes DW/2 bit pairs; keep at least one bit for DW=2.
  function automatic int beat_w(input int dw);
    return (dw / 2 > 1) ? $clog2(dw / 2) : 1;
  endfunction
endpackage

// File: rtl/ddr_tx_fifo.sv
// Small synchronous FIFO feeding the serializer; pop returns the oldest word.
module ddr_tx_fifo
  import ddr_tx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ddr_tx_serializer.sv
// Serializes FIFO words onto a DDR pin, two bits per clock, LSB first.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   en,
  output logic                   dq,
  output logic                   dq_frame,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int BW = beat_w(DW);
  localparam logic [BW-1:0] LAST = BW'(DW / 2 - 1);

  logic          pop, full, empty;
  logic [DW-1:0] rdata;

  state_e        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          p_q, p_d, n_q, n_d, odd_q, odd_d;
  logic          frame_q, frame_d, busy_q, busy_d;

  ddr_tx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign in_ready = !full;
  assign dq       = p_q ^ n_q;
  assign dq_frame = frame_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    frame_d = 1'b0;
    odd_d   = 1'b0;
    // Even bit of zero keeps dq at 0 while nothing is transmitted.
    p_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          shift_d = rdata;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        frame_d = 1'b1;
        p_d     = shift_q[0] ^ n_q;
        odd_d   = shift_q[1];
        shift_d = shift_q >> 2;
        beat_d  = beat_q + BW'(1);
        if (beat_q == LAST) begin
          if (en && !empty) begin
            pop     = 1'b1;
            shift_d = rdata;
            beat_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = frame_d;
    n_d    = odd_q ^ p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      beat_q  <= '0;
      p_q     <= 1'b0;
      odd_q   <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      p_q     <= p_d;
      odd_q   <= odd_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  // Low-phase half of the XOR pair; odd_q is stable since the preceding posedge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) n_q <= 1'b0;
    else        n_q <= n_d;
  end
endmodule
